// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg: shared FSM state encoding and default counter width
package pulse_stretcher_pkg;
    localparam int CNT_W_DEF = 8;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;
endpackage

// File: rtl/pulse_stretcher_load_down_counter.sv
// load_down_counter: loadable down counter with enable and zero flag, saturating at 0
module load_down_counter
    import pulse_stretcher_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_en && !o_zero)
            r_cnt <= r_cnt - CNT_W'(1);
    end
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: trigger to N-cycle level pulse with hold-off; PULSE_RETRIGGER_EN lets ACTIVE triggers extend the pulse
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    output logic             pulse_out,
    output logic             busy,
    output logic             dropped
);
`ifdef PULSE_RETRIGGER_EN
    localparam logic RETRIG = 1'b1;
`else
    localparam logic RETRIG = 1'b0;
`endif
    state_t           r_state;
    logic [CNT_W-1:0] r_g;
    logic             r_pulse, r_busy, r_dropped;
    logic             w_accept, w_load, w_en, w_zero;
    logic [CNT_W-1:0] w_val;
    always_comb begin
        w_accept = trig && (r_state == ST_IDLE || (RETRIG && r_state == ST_ACTIVE));
        w_load   = w_accept || (r_state == ST_ACTIVE && w_zero && r_g != '0);
        w_val    = w_accept ? ((width == '0) ? '0 : width - CNT_W'(1)) : r_g - CNT_W'(1);
        w_en     = r_state != ST_IDLE;
    end
    load_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_en   (w_en),
        .i_val  (w_val),
        .o_zero (w_zero)
    );
    // a trigger wins over the end-of-pulse edge, so a retrigger on the last ACTIVE cycle never glitches low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_g       <= '0;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= trig && !w_accept;
            if (w_accept) begin
                r_state <= ST_ACTIVE;
                r_g     <= gap;
                r_pulse <= 1'b1;
                r_busy  <= 1'b1;
            end else if (r_state == ST_ACTIVE && w_zero) begin
                r_state <= (r_g != '0) ? ST_HOLDOFF : ST_IDLE;
                r_pulse <= 1'b0;
                r_busy  <= (r_g != '0);
            end else if (r_state == ST_HOLDOFF && w_zero) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end
        end
    end
    assign pulse_out = r_pulse;
    assign busy      = r_busy;
    assign dropped   = r_dropped;
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: table vectors, hand-written corner sequences and a random run against an interval-based model
module tb_pulse_stretcher;
`ifdef PULSE_RETRIGGER_EN
    localparam logic RETRIG = 1'b1;
`else
    localparam logic RETRIG = 1'b0;
`endif
    typedef struct {
        logic       t;
        logic [7:0] w;
        logic [7:0] g;
        logic       p;
        logic       b;
        logic       d;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [7:0] width;
    logic [7:0] gap;
    logic       pulse_out, busy, dropped;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         m_n, m_plast, m_free;
    logic       m_p, m_b, m_d;
    vec_t       tbl[$];
    pulse_stretcher #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .width     (width),
        .gap       (gap),
        .pulse_out (pulse_out),
        .busy      (busy),
        .dropped   (dropped)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, expected %0b", name, got, exp);
        end
    endtask
    // drive inputs 3 ns after a posedge, let the next edge sample them, return 3 ns after it
    task automatic cyc(input logic t, input logic [7:0] w, input logic [7:0] g);
        trig  = t;
        width = w;
        gap   = g;
        @(posedge clk);
        #3;
    endtask
    task automatic model_reset();
        m_n     = 0;
        m_plast = -10;
        m_free  = 0;
    endtask
    // pulse covers edges [k, plast]; next free accept edge is k+W+G+1; ACTIVE sampling edges end at plast+1
    task automatic model_step(input logic t, input logic [7:0] w, input logic [7:0] g);
        int wl;
        wl  = (w == 0) ? 1 : int'(w);
        m_d = 1'b0;
        if (t && (m_n >= m_free || (RETRIG && m_n <= m_plast + 1))) begin
            m_plast = m_n + wl - 1;
            m_free  = m_n + wl + int'(g) + 1;
        end else if (t) begin
            m_d = 1'b1;
        end
        m_p = (m_n <= m_plast);
        m_b = (m_n <= m_free - 2);
        m_n++;
    endtask
    task automatic do_reset();
        rst  = 1'b0;
        trig = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
    endtask
    initial begin
        rst   = 1'b0;
        trig  = 1'b0;
        width = 8'd0;
        gap   = 8'd0;
        repeat (2) @(posedge clk);
        #3;
        chk("reset pulse_out", pulse_out, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset dropped", dropped, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 8'd0, 8'd0);
        tbl.push_back(vec_t'{1'b1, 8'd4, 8'd0, 1'b1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd9, 8'd5, 1'b1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd9, 8'd5, 1'b1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd9, 8'd5, 1'b1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd9, 8'd5, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 8'd3, 8'd2, 1'b1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd3, 8'd2, 1'b1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd3, 8'd2, 1'b1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd3, 8'd2, 1'b0, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd3, 8'd2, 1'b0, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b1, 8'd3, 8'd2, 1'b0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{1'b1, 8'd3, 8'd2, 1'b1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd3, 8'd2, 1'b1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd3, 8'd2, 1'b1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd3, 8'd2, 1'b0, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd3, 8'd2, 1'b0, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'd3, 8'd2, 1'b0, 1'b0, 1'b0});
        foreach (tbl[i]) begin
            cyc(tbl[i].t, tbl[i].w, tbl[i].g);
            chk($sformatf("tbl[%0d] pulse_out", i), pulse_out, tbl[i].p);
            chk($sformatf("tbl[%0d] busy", i), busy, tbl[i].b);
            chk($sformatf("tbl[%0d] dropped", i), dropped, tbl[i].d);
        end
        // width=5, triggers on edges 0 and 3
        for (int n = 0; n < 10; n++) begin
            cyc(n == 0 || n == 3, 8'd5, 8'd0);
            chk($sformatf("retrig e%0d pulse_out", n), pulse_out, n <= (RETRIG ? 7 : 4));
            chk($sformatf("retrig e%0d busy", n), busy, n <= (RETRIG ? 7 : 4));
            chk($sformatf("retrig e%0d dropped", n), dropped, !RETRIG && n == 3);
        end
        // width=2, gap=0, trigger held for 10 edges
        for (int n = 0; n < 10; n++) begin
            cyc(1'b1, 8'd2, 8'd0);
            chk($sformatf("held e%0d pulse_out", n), pulse_out, RETRIG || (n % 3 != 2));
            chk($sformatf("held e%0d dropped", n), dropped, !RETRIG && (n % 3 != 0));
        end
        repeat (4) cyc(1'b0, 8'd0, 8'd0);
        chk("held drained busy", busy, 1'b0);
        // asynchronous reset in ACTIVE cycle 2 of a 6-cycle pulse
        for (int n = 0; n < 3; n++) begin
            cyc(n == 0, 8'd6, 8'd0);
            chk($sformatf("arst e%0d pulse_out", n), pulse_out, 1'b1);
        end
        #1 rst = 1'b0;
        #1;
        chk("arst pulse_out immediate", pulse_out, 1'b0);
        chk("arst busy immediate", busy, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        for (int n = 0; n < 5; n++) begin
            cyc(1'b0, 8'd6, 8'd0);
            chk($sformatf("post-arst e%0d pulse_out", n), pulse_out, 1'b0);
            chk($sformatf("post-arst e%0d busy", n), busy, 1'b0);
        end
        cyc(1'b1, 8'd6, 8'd0);
        chk("post-arst new trig pulse_out", pulse_out, 1'b1);
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic       t;
            logic [7:0] w, g;
            t = ($urandom_range(0, 9) < 3);
            w = 8'($urandom_range(0, 5));
            g = 8'($urandom_range(0, 3));
            cyc(t, w, g);
            model_step(t, w, g);
            chk($sformatf("rand c%0d pulse_out", n), pulse_out, m_p);
            chk($sformatf("rand c%0d busy", n), busy, m_b);
            chk($sformatf("rand c%0d dropped", n), dropped, m_d);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
